// File: rtl/pipe_stall_ctrl.sv
// Central stall controller: load-use hazard detection, multi-cycle divide
// sequencing, stall-bus arbitration and ID instruction hold while ID is frozen.
module pipe_stall_ctrl #(
  parameter int STALL_WD   = 6,
  parameter int DIV_CYCLES = 33
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          id_rs,
  input  logic [4:0]          id_rt,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic                ex_is_load,
  input  logic [4:0]          ex_rf_waddr,
  input  logic                ex_div_req,
  input  logic                mem_stallreq,
  input  logic [31:0]         inst_sram_rdata,
  output logic [31:0]         id_inst,
  output logic [STALL_WD-1:0] stall,
  output logic                div_busy,
  output logic                div_done
);

  localparam logic [5:0] CNT_LAST = 6'(DIV_CYCLES - 1);

  typedef enum logic {
    RUN,
    DIV_WAIT
  } state_t;

  state_t      state, state_nx;
  logic [5:0]  cnt, cnt_nx;
  logic        lu;
  logic        div_stall;
  logic        busy_raw;
  logic        done_raw;
  logic        hold_r;
  logic [31:0] inst_buf;

  assign lu = ex_is_load & (ex_rf_waddr != 5'd0) &
              ((id_rs_used & (id_rs == ex_rf_waddr)) |
               (id_rt_used & (id_rt == ex_rf_waddr)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 6'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The counter freezes while MEM waits, so a memory stall stretches the divide window.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    div_stall = 1'b0;
    busy_raw  = 1'b0;
    done_raw  = 1'b0;
    case (state)
      RUN: begin
        if (ex_div_req) begin
          div_stall = 1'b1;
          busy_raw  = 1'b1;
          state_nx  = DIV_WAIT;
          cnt_nx    = 6'd1;
        end
      end
      DIV_WAIT: begin
        busy_raw = 1'b1;
        if ((cnt == CNT_LAST) && !mem_stallreq) begin
          done_raw = 1'b1;
          state_nx = RUN;
          cnt_nx   = 6'd0;
        end else begin
          div_stall = 1'b1;
          if (!mem_stallreq) cnt_nx = cnt + 6'd1;
        end
      end
      default: begin
        state_nx = RUN;
        cnt_nx   = 6'd0;
      end
    endcase
  end

  assign div_busy = busy_raw & ~rst;
  assign div_done = done_raw & ~rst;

  always_comb begin
    stall = '0;
    if (!rst) begin
      if (mem_stallreq)   stall = STALL_WD'(6'b011111);
      else if (div_stall) stall = STALL_WD'(6'b001111);
      else if (lu)        stall = STALL_WD'(6'b000111);
    end
  end

  // ID reads the SRAM port directly, so the word seen on the first frozen cycle is latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r   <= 1'b0;
      inst_buf <= 32'd0;
    end else if (stall[2]) begin
      if (!hold_r) begin
        inst_buf <= inst_sram_rdata;
        hold_r   <= 1'b1;
      end
    end else begin
      hold_r <= 1'b0;
    end
  end

  assign id_inst = hold_r ? inst_buf : inst_sram_rdata;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares the combinational outputs.
module tb_pipe_stall_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_rs_used;
  logic        id_rt_used;
  logic        ex_is_load;
  logic [4:0]  ex_rf_waddr;
  logic        ex_div_req;
  logic        mem_stallreq;
  logic [31:0] inst_sram_rdata;
  logic [31:0] id_inst;
  logic [5:0]  stall;
  logic        div_busy;
  logic        div_done;

  typedef struct {
    logic [5:0]  stall;
    logic        busy;
    logic        done;
    logic [31:0] inst;
    int          step;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_LU   = 6'b000111;
  localparam logic [5:0] S_DIV  = 6'b001111;
  localparam logic [5:0] S_MEM  = 6'b011111;

  pipe_stall_ctrl #(.STALL_WD(6), .DIV_CYCLES(33)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rs_used      (id_rs_used),
    .id_rt_used      (id_rt_used),
    .ex_is_load      (ex_is_load),
    .ex_rf_waddr     (ex_rf_waddr),
    .ex_div_req      (ex_div_req),
    .mem_stallreq    (mem_stallreq),
    .inst_sram_rdata (inst_sram_rdata),
    .id_inst         (id_inst),
    .stall           (stall),
    .div_busy        (div_busy),
    .div_done        (div_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic [5:0] e_stall, input logic e_busy,
                                input logic e_done, input logic [31:0] e_inst);
    exp_t e;
    e.stall = e_stall;
    e.busy  = e_busy;
    e.done  = e_done;
    e.inst  = e_inst;
    e.step  = step;
    exp_q.push_back(e);
    step++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input exp_t e);
    checks++;
    if ({stall, div_busy, div_done, id_inst} !== {e.stall, e.busy, e.done, e.inst}) begin
      errors++;
      $display("[TB] FAIL outputs@step%0d: got stall=%b busy=%b done=%b inst=%h, want stall=%b busy=%b done=%b inst=%h",
               e.step, stall, div_busy, div_done, id_inst, e.stall, e.busy, e.done, e.inst);
    end
  endtask

  // Monitor: the outputs are combinational, so every cycle presents one response.
  always @(negedge clk) begin
    if (exp_q.size() > 0) check_output(exp_q.pop_front());
  end

  task automatic idle_inputs();
    id_rs        = 5'd0;
    id_rt        = 5'd0;
    id_rs_used   = 1'b0;
    id_rt_used   = 1'b0;
    ex_is_load   = 1'b0;
    ex_rf_waddr  = 5'd0;
    ex_div_req   = 1'b0;
    mem_stallreq = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    inst_sram_rdata = 32'hDEAD_0001;
    @(posedge clk);
    #1;

    // Reset holds outputs low even with divide and memory requests asserted
    apply_stimulus(S_NONE, 1'b0, 1'b0, 32'hDEAD_0001);
    ex_div_req   = 1'b1;
    mem_stallreq = 1'b1;
    apply_stimulus(S_NONE, 1'b0, 1'b0, 32'hDEAD_0001);
    rst = 1'b0;
    idle_inputs();
    apply_stimulus(S_NONE, 1'b0, 1'b0, 32'hDEAD_0001);

    // Load-use on rs with instruction hold
    ex_is_load = 1'b1; ex_rf_waddr = 5'd5; id_rs = 5'd5; id_rs_used = 1'b1;
    inst_sram_rdata = 32'h3C01_0001;
    apply_stimulus(S_LU, 1'b0, 1'b0, 32'h3C01_0001);
    ex_is_load = 1'b0;
    inst_sram_rdata = 32'h2442_0004;
    apply_stimulus(S_NONE, 1'b0, 1'b0, 32'h3C01_0001);
    inst_sram_rdata = 32'h2442_0008;
    apply_stimulus(S_NONE, 1'b0, 1'b0, 32'h2442_0008);

    // Load-use on rt, then non-hazard cases
    idle_inputs();
    inst_sram_rdata = 32'h8C22_0000;
    ex_is_load = 1'b1; ex_rf_waddr = 5'd7; id_rt = 5'd7; id_rt_used = 1'b1; id_rs = 5'd3; id_rs_used = 1'b1;
    apply_stimulus(S_LU, 1'b0, 1'b0, 32'h8C22_0000);
    idle_inputs();
    ex_is_load = 1'b1; ex_rf_waddr = 5'd0; id_rs = 5'd0; id_rs_used = 1'b1;
    apply_stimulus(S_NONE, 1'b0, 1'b0, 32'h8C22_0000);
    ex_rf_waddr = 5'd9; id_rs = 5'd9; id_rs_used = 1'b0;
    apply_stimulus(S_NONE, 1'b0, 1'b0, 32'h8C22_0000);
    ex_is_load = 1'b0; id_rs_used = 1'b1;
    apply_stimulus(S_NONE, 1'b0, 1'b0, 32'h8C22_0000);
    idle_inputs();

    // Plain divide with a coincident load-use on cycle 0; the held word survives
    ex_div_req = 1'b1;
    ex_is_load = 1'b1; ex_rf_waddr = 5'd3; id_rs = 5'd3; id_rs_used = 1'b1;
    inst_sram_rdata = 32'hA000_0000;
    apply_stimulus(S_DIV, 1'b1, 1'b0, 32'hA000_0000);
    ex_is_load = 1'b0; id_rs_used = 1'b0;
    inst_sram_rdata = 32'hA000_0001;
    for (int i = 1; i < 32; i++) apply_stimulus(S_DIV, 1'b1, 1'b0, 32'hA000_0000);
    apply_stimulus(S_NONE, 1'b1, 1'b1, 32'hA000_0000);
    ex_div_req = 1'b0;
    apply_stimulus(S_NONE, 1'b0, 1'b0, 32'hA000_0001);

    // Divide with three memory-wait cycles starting at cycle index 9
    inst_sram_rdata = 32'hB000_0000;
    ex_div_req = 1'b1;
    for (int i = 0; i < 35; i++) begin
      mem_stallreq = (i >= 9 && i <= 11);
      apply_stimulus((i >= 9 && i <= 11) ? S_MEM : S_DIV, 1'b1, 1'b0, 32'hB000_0000);
    end
    mem_stallreq = 1'b0;
    apply_stimulus(S_NONE, 1'b1, 1'b1, 32'hB000_0000);
    ex_div_req = 1'b0;
    apply_stimulus(S_NONE, 1'b0, 1'b0, 32'hB000_0000);

    // Back-to-back divides: done pulses 33 cycles apart
    inst_sram_rdata = 32'hC000_0000;
    ex_div_req = 1'b1;
    for (int i = 0; i < 66; i++) begin
      if (i == 32 || i == 65) apply_stimulus(S_NONE, 1'b1, 1'b1, 32'hC000_0000);
      else                    apply_stimulus(S_DIV, 1'b1, 1'b0, 32'hC000_0000);
    end
    ex_div_req = 1'b0;
    apply_stimulus(S_NONE, 1'b0, 1'b0, 32'hC000_0000);

    // Reset at divide cycle 5 abandons the divide; a new one counts from zero
    inst_sram_rdata = 32'hD000_0000;
    ex_div_req = 1'b1;
    apply_stimulus(S_DIV, 1'b1, 1'b0, 32'hD000_0000);
    inst_sram_rdata = 32'hD000_0001;
    for (int i = 1; i < 5; i++) apply_stimulus(S_DIV, 1'b1, 1'b0, 32'hD000_0000);
    rst = 1'b1;
    apply_stimulus(S_NONE, 1'b0, 1'b0, 32'hD000_0000);
    rst = 1'b0;
    ex_div_req = 1'b0;
    apply_stimulus(S_NONE, 1'b0, 1'b0, 32'hD000_0001);
    ex_div_req = 1'b1;
    for (int i = 0; i < 32; i++) apply_stimulus(S_DIV, 1'b1, 1'b0, 32'hD000_0001);
    apply_stimulus(S_NONE, 1'b1, 1'b1, 32'hD000_0001);
    ex_div_req = 1'b0;
    apply_stimulus(S_NONE, 1'b0, 1'b0, 32'hD000_0001);

    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
